// File: rtl/mm_pkg.sv
// Shared definitions for the word-serial 149x149 multiplier.
// Holds the operand/digit/result widths, the control FSM state encoding,
// the tag that travels alongside each partial product through the
// multiplier pipeline, and a helper that turns a digit index into a shift.
package mm_pkg;

  localparam int AW       = 149;            // operand width
  localparam int DW       = 64;             // digit width of b
  localparam int NDIG     = (AW + DW - 1) / DW;
  localparam int MULT_LAT = 3;              // mult_149x64 operand-to-product latency
  localparam int PW       = 2 * AW;         // full product width
  localparam int BW       = NDIG * DW;      // b zero-extended to whole digits
  localparam int PPW      = AW + DW;        // partial product width

  localparam logic [1:0] LAST_IDX = 2'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // Travels with each digit product so the accumulator knows whether the
  // multiplier output is live and which 64-bit position it belongs to.
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;

  function automatic int unsigned digit_shift(logic [1:0] idx);
    return DW * int'(idx);
  endfunction

endpackage

// File: rtl/mult_seq_149x149_if.sv
// Operand/result handshake bundle for mult_seq_149x149.
//   in_valid/in_ready/in_a/in_b     : operand pair, valid/ready
//   out_valid/out_ready/out_p       : full product, valid/ready
// slave  : the multiplier side (accepts operands, produces products)
// master : the source/sink side driving operands and consuming products
interface mult_seq_149x149_if;
  import mm_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_a;
  logic [AW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

endinterface

// File: rtl/mult_149x64.sv
// Pipelined 149x64-bit unsigned multiplier.
//   clk : system clock
//   a   : 149-bit multiplicand
//   b   : 64-bit multiplier digit
//   p   : 213-bit product, valid MULT_LAT cycles after a/b are presented
// Stage 1 captures the operands, stage 2 the raw product, stage 3 retimes
// it. No reset: contents are qualified by the caller's tag pipeline.
module mult_149x64
  import mm_pkg::*;
(
  input  logic           clk,
  input  logic [AW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic [PPW-1:0] p
);

  logic [AW-1:0]  op_a_q, op_a_d;
  logic [DW-1:0]  op_b_q, op_b_d;
  logic [PPW-1:0] prod1_q, prod1_d;
  logic [PPW-1:0] prod2_q, prod2_d;

  always_comb begin
    op_a_d  = a;
    op_b_d  = b;
    prod1_d = {{DW{1'b0}}, op_a_q} * {{AW{1'b0}}, op_b_q};
    prod2_d = prod1_q;
  end

  always_ff @(posedge clk) begin
    op_a_q  <= op_a_d;
    op_b_q  <= op_b_d;
    prod1_q <= prod1_d;
    prod2_q <= prod2_d;
  end

  assign p = prod2_q;

endmodule

// File: rtl/mult_seq_149x149.sv
// Word-serial 149x149-bit multiplier.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : slave side of mult_seq_149x149_if (operand in, product out)
// Operand b is cut into NDIG 64-bit digits issued one per cycle against a
// held a into a single mult_149x64. A tag shift register matching the
// multiplier latency marks which returning products are live and their
// digit position; each is added into the 298-bit accumulator at 64*idx.
module mult_seq_149x149
  import mm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mult_seq_149x149_if.slave   bus
);

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [AW-1:0]  a_q, a_d;
  logic [BW-1:0]  b_q, b_d;
  logic [PW-1:0]  acc_q, acc_d;
  tag_t           tag_q [MULT_LAT];
  tag_t           tag_d [MULT_LAT];

  tag_t           tag_in;
  tag_t           tag_out;
  logic           in_ready_c;
  logic           out_valid_c;
  logic [DW-1:0]  mult_b;
  logic [PPW-1:0] mult_p;
  logic [PW-1:0]  pp_ext;

  mult_149x64 u_mult (
    .clk (clk),
    .a   (a_q),
    .b   (mult_b),
    .p   (mult_p)
  );

  assign mult_b  = b_q[digit_shift(cnt_q) +: DW];
  assign tag_out = tag_q[MULT_LAT-1];
  assign pp_ext  = PW'(mult_p);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    tag_in      = '0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    // Live products can only come from the operation in flight, so they
    // are folded in regardless of the current state.
    if (tag_out.valid) begin
      acc_d = acc_q + (pp_ext << digit_shift(tag_out.idx));
    end

    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = BW'(bus.in_b);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tag_in = '{valid: 1'b1, idx: cnt_q};
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DRAIN: begin
        if (tag_out.valid && tag_out.idx == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tag_d[0] = tag_in;
    for (int i = 1; i < MULT_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // NOTE: operand registers carry no reset; they are always reloaded on
  // acceptance before being used, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = in_ready_c & ~rst;
  assign bus.out_valid = out_valid_c;
  assign bus.out_p     = acc_q;

endmodule

// File: tb/tb_mult_seq_149x149.sv
// Self-checking bench for mult_seq_149x149: directed cases plus a random
// back-to-back run scored against a plain-arithmetic product model.
module tb_mult_seq_149x149;
  import mm_pkg::*;

  logic clk = 1'b0;
  logic rst;

  mult_seq_149x149_if bus ();

  mult_seq_149x149 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [AW-1:0] a,
                                          input logic [AW-1:0] b);
    logic [PW-1:0] wa, wb;
    wa = PW'(a);
    wb = PW'(b);
    return wa * wb;
  endfunction

  function automatic logic [AW-1:0] rand_op();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[AW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair and returns after the accepting edge (now in cycle 1).
  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_in_ready", PW'(bus.in_ready), PW'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle index where out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [AW-1:0] a, b;
    logic [AW-1:0] next_a, next_b;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp;
    int cyc, last_acc, sent, got;
    bit acc_now, out_now;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", PW'(bus.in_ready), PW'(0));
    rst = 1'b0;
    #1;
    check("rst_idle_in_ready", PW'(bus.in_ready), PW'(1));
    check("rst_out_valid", PW'(bus.out_valid), PW'(0));
    check("rst_out_p", bus.out_p, '0);

    // 1 x 1: latency and return to IDLE.
    send(149'd1, 149'd1);
    wait_out(lat);
    check("one_latency", PW'(lat), PW'(7));
    check("one_p", bus.out_p, PW'(1));
    tick();
    check("one_in_ready_after", PW'(bus.in_ready), PW'(1));
    check("one_out_valid_after", PW'(bus.out_valid), PW'(0));

    // All ones: carries across every digit boundary.
    a = '1;
    b = '1;
    send(a, b);
    wait_out(lat);
    check("ones_latency", PW'(lat), PW'(7));
    check("ones_p", bus.out_p, model(a, b));
    exp = '1;
    exp = exp - (PW'(1) << 150) + PW'(2);
    check("ones_closed_form", bus.out_p, exp);
    tick();

    // b = 2^128: only the top digit contributes.
    a = 149'h1234_5678_9ABC_DEF0;
    b = 149'd1 << 128;
    send(a, b);
    wait_out(lat);
    check("shift_p", bus.out_p, PW'(a) << 128);
    tick();

    // Backpressure: DONE held while out_ready is low.
    bus.out_ready = 1'b0;
    send(149'd3, 149'd5);
    wait_out(lat);
    check("bp_latency", PW'(lat), PW'(7));
    bus.in_valid = 1'b1;
    bus.in_a     = 149'd100;
    bus.in_b     = 149'd100;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", PW'(bus.out_valid), PW'(1));
      check("bp_out_p", bus.out_p, PW'(15));
      check("bp_in_ready", PW'(bus.in_ready), PW'(0));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_valid", PW'(bus.out_valid), PW'(1));
    tick();
    check("bp_idle_in_ready", PW'(bus.in_ready), PW'(1));
    check("bp_idle_out_valid", PW'(bus.out_valid), PW'(0));
    tick();
    tick();
    check("bp_no_second_op", PW'(bus.in_ready), PW'(1));

    // Reset mid-ISSUE discards the first pair.
    send(149'd7, 149'd9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", PW'(bus.out_valid), PW'(0));
    check("midrst_in_ready", PW'(bus.in_ready), PW'(1));
    send(149'd2, 149'd3);
    wait_out(lat);
    check("midrst_latency", PW'(lat), PW'(7));
    check("midrst_p", bus.out_p, PW'(6));
    tick();

    // 20 random back-to-back pairs, random out_ready.
    cyc      = 0;
    last_acc = -100;
    sent     = 0;
    got      = 0;
    next_a   = rand_op();
    next_b   = rand_op();
    bus.in_valid = 1'b1;
    bus.in_a     = next_a;
    bus.in_b     = next_b;
    while (got < 20 && cyc < 4000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc_now = bus.in_valid && bus.in_ready;
      out_now = bus.out_valid && bus.out_ready;
      if (out_now) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_out", bus.out_p, '0);
          check("rand_queue_empty", PW'(1), PW'(0));
        end else begin
          check("rand_p", bus.out_p, exp_q.pop_front());
        end
        got++;
      end
      if (acc_now) begin
        exp_q.push_back(model(bus.in_a, bus.in_b));
        if (sent > 0) begin
          check("rand_ii_ok", PW'(cyc - last_acc >= 8), PW'(1));
        end
        last_acc = cyc;
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc_now) begin
        if (sent < 20) begin
          bus.in_a = rand_op();
          bus.in_b = rand_op();
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("rand_all_received", PW'(got), PW'(20));
    bus.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_149x149.md
Name: mult_seq_149x149

Overview:
- Word-serial 149x149-bit multiplier for the modular-multiplication datapath.
- Splits operand b into 64-bit digits and feeds them one per cycle, with a held, into one instance of mult_149x64.
- Accumulates the returning 213-bit partial products, shifted by 64*k, into a 298-bit full product.
- Uses valid/ready handshakes on both sides. Feeds the downstream reduction stage.

Parameters:
- AW, 149: width of operands a and b.
- DW, 64: digit width of b; fixed by mult_149x64.
- NDIG, 3: number of b digits, ceil(AW/DW). The top digit is zero-extended (21 live bits).
- MULT_LAT, 3: register latency of mult_149x64, operand-in to product-valid, in clk cycles.
- PW, 298: result width, 2*AW.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  AW  multiplicand
- in_b  in  AW  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- out_p  out  PW  in_a*in_b

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE; out_valid=0; out_p=0; accumulator=0; digit counter=0; tag pipeline all invalid.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready (cycle 0), register a and b zero-extended to NDIG*DW, clear the accumulator, go to ISSUE.
  - ISSUE: for k = 0..NDIG-1, drive mult.a=a_reg and mult.b=b_reg[DW*k +: DW] in cycle 1+k. Push tag {valid=1, idx=k} into a MULT_LAT-deep shift register. After k=NDIG-1, go to DRAIN.
  - DRAIN: wait for the returning products. When the tag leaving the shift register is valid, register acc <= acc + (p << DW*idx), truncated to PW. The last product (idx=NDIG-1) is added in cycle NDIG+MULT_LAT; then go to DONE.
  - DONE: out_valid=1, out_p=acc, held stable until out_ready. On out_valid&&out_ready, go to IDLE with out_valid=0.
- Latency: out_valid rises in cycle NDIG+MULT_LAT+1 after acceptance, which is 7 with defaults. Minimum initiation interval is NDIG+MULT_LAT+2.
- in_ready is 1 only in IDLE. There is no overlap of consecutive operations. A handshake in the same cycle as the out handshake is not accepted.
- Outside ISSUE, the tag pushed is invalid. Multiplier outputs with invalid tags are ignored. The multiplier has no reset, so its pipeline contents after reset are don't-care.
- Width rule: a partial product for digit k is below 2^(AW+DW), and the top digit is below 2^21. The exact sum is therefore below 2^PW, so truncation to PW never loses bits.
- Backpressure: out_ready=0 holds DONE indefinitely. in_a and in_b are don't-care after acceptance.
- Reset mid-operation: any state goes to IDLE next cycle. Tags are cleared, the accumulator is cleared, out_valid=0, and in-flight products are discarded.
- in_valid while busy is ignored (in_ready=0). The source must hold its data.

Decomposition:
- Shared package mm_pkg holds:
  - AW, DW, NDIG, PW constants;
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - tag struct {logic valid; logic [1:0] idx}.
- One sub-module: mult_149x64, instantiated once. The tag shift register and accumulator stay inline.

Test Plan:
- a=1, b=1, out_ready=1 -> out_valid in cycle 7 after acceptance, out_p=1, in_ready=1 the cycle after the out handshake.
- a=2^149-1, b=2^149-1 -> out_p=2^298-2^150+1 (exercises the carry across all digit boundaries and the 21-bit top digit).
- a=0x1234_5678_9ABC_DEF0 with upper bits 0, b=2^128 -> out_p=a<<128; only the idx=2 contribution is nonzero.
- a=3, b=5, out_ready held 0 for 10 cycles after out_valid -> out_valid and out_p=15 stable throughout, in_ready=0, a second in_valid is not accepted; out_ready=1 -> handshake, then IDLE.
- Accept a=7, b=9; assert rst in cycle 3 (mid-ISSUE); then accept a=2, b=3 -> no output for the first pair, out_p=6 in cycle 7 of the second.
- 20 back-to-back random pairs with in_valid always high and random out_ready -> each out_p matches the reference model in order, and the initiation interval is at least 8 cycles.
